// File: rtl/cook_timer_sequencer_if.sv
// cook_timer_sequencer_if: keypad, button, door and display/magnetron signals of the cook timer
interface cook_timer_sequencer_if;
    logic [3:0] D;
    logic       LOAD_N;
    logic       TICK_1HZ;
    logic       START_N;
    logic       STOP_N;
    logic       CLEAR_N;
    logic       DOOR_CLOSED;
    logic       EN_N;
    logic [3:0] MIN_TENS;
    logic [3:0] MIN_ONES;
    logic [3:0] SEC_TENS;
    logic [3:0] SEC_ONES;
    logic       MAG_ON;
    logic       DONE;

    modport master (
        output D, LOAD_N, TICK_1HZ, START_N, STOP_N, CLEAR_N, DOOR_CLOSED,
        input  EN_N, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, MAG_ON, DONE
    );

    modport slave (
        input  D, LOAD_N, TICK_1HZ, START_N, STOP_N, CLEAR_N, DOOR_CLOSED,
        output EN_N, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, MAG_ON, DONE
    );
endinterface

// File: rtl/cook_timer_sequencer.sv
// cook_timer_sequencer: keypad time entry, BCD cook countdown, door interlock and done indication
module cook_timer_sequencer #(
    parameter int DONE_CYCLES = 300
) (
    input logic                    CLK_100HZ,
    input logic                    RST_N,
    cook_timer_sequencer_if.slave  bus
);
    localparam int CW = $clog2(DONE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COOK, PAUSE, FINISH} state_t;

    state_t        r_state;
    logic [3:0]    r_mt, r_mo, r_st, r_so;
    logic          r_load_prev, r_start_prev, r_stop_prev, r_clear_prev, r_tick_prev;
    logic [CW-1:0] r_cnt;
    logic          r_en_n, r_mag_on, r_done;

    logic       w_load_ev, w_start_ev, w_stop_ev, w_clear_ev, w_tick_ev;
    logic [3:0] w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic       w_bor_st, w_bor_mo, w_bor_mt;
    logic       w_time_nz, w_dec_zero;

    assign w_load_ev  = r_load_prev  & ~bus.LOAD_N;
    assign w_start_ev = r_start_prev & ~bus.START_N;
    assign w_stop_ev  = r_stop_prev  & ~bus.STOP_N;
    assign w_clear_ev = r_clear_prev & ~bus.CLEAR_N;
    assign w_tick_ev  = ~r_tick_prev & bus.TICK_1HZ;

    assign w_time_nz  = |{r_mt, r_mo, r_st, r_so};
    assign w_dec_zero = ~|{w_dec_mt, w_dec_mo, w_dec_st, w_dec_so};

    // One-second BCD decrement; seconds tens wrap to 5 so entered values above 59 count down unnormalised
    always_comb begin
        w_bor_st = r_so == 4'd0;
        w_bor_mo = w_bor_st && r_st == 4'd0;
        w_bor_mt = w_bor_mo && r_mo == 4'd0;
        w_dec_so = w_bor_st ? 4'd9 : r_so - 4'd1;
        w_dec_st = !w_bor_st ? r_st : (r_st == 4'd0 ? 4'd5 : r_st - 4'd1);
        w_dec_mo = !w_bor_mo ? r_mo : (r_mo == 4'd0 ? 4'd9 : r_mo - 4'd1);
        w_dec_mt = w_bor_mt ? r_mt - 4'd1 : r_mt;
    end

    // Control FSM: edge registers, digits, done counter and registered outputs
    always_ff @(posedge CLK_100HZ) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            {r_mt, r_mo, r_st, r_so} <= 16'h0000;
            r_load_prev  <= 1'b1;
            r_start_prev <= 1'b1;
            r_stop_prev  <= 1'b1;
            r_clear_prev <= 1'b1;
            r_tick_prev  <= 1'b0;
            r_cnt        <= '0;
            r_en_n       <= 1'b0;
            r_mag_on     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_load_prev  <= bus.LOAD_N;
            r_start_prev <= bus.START_N;
            r_stop_prev  <= bus.STOP_N;
            r_clear_prev <= bus.CLEAR_N;
            r_tick_prev  <= bus.TICK_1HZ;
            case (r_state)
                IDLE: begin
                    if (w_clear_ev) begin
                        {r_mt, r_mo, r_st, r_so} <= 16'h0000;
                    end else if (w_start_ev && bus.DOOR_CLOSED && w_time_nz) begin
                        r_state  <= COOK;
                        r_en_n   <= 1'b1;
                        r_mag_on <= 1'b1;
                    end else if (w_load_ev && bus.D <= 4'd9) begin
                        {r_mt, r_mo, r_st, r_so} <= {r_mo, r_st, r_so, bus.D};
                    end
                end
                COOK: begin
                    if (w_clear_ev) begin
                        r_state  <= IDLE;
                        {r_mt, r_mo, r_st, r_so} <= 16'h0000;
                        r_en_n   <= 1'b0;
                        r_mag_on <= 1'b0;
                    end else if (!bus.DOOR_CLOSED) begin
                        r_state  <= PAUSE;
                        r_mag_on <= 1'b0;
                    end else begin
                        if (w_tick_ev) begin
                            {r_mt, r_mo, r_st, r_so} <= {w_dec_mt, w_dec_mo, w_dec_st, w_dec_so};
                        end
                        if (w_tick_ev && w_dec_zero) begin
                            r_state  <= FINISH;
                            r_mag_on <= 1'b0;
                            r_done   <= 1'b1;
                            r_cnt    <= CW'(DONE_CYCLES);
                        end else if (w_stop_ev) begin
                            r_state  <= PAUSE;
                            r_mag_on <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (w_clear_ev) begin
                        r_state <= IDLE;
                        {r_mt, r_mo, r_st, r_so} <= 16'h0000;
                        r_en_n  <= 1'b0;
                    end else if (w_stop_ev) begin
                        r_state <= IDLE;
                        r_en_n  <= 1'b0;
                    end else if (w_start_ev && bus.DOOR_CLOSED) begin
                        r_state  <= COOK;
                        r_mag_on <= 1'b1;
                    end
                end
                FINISH: begin
                    if (w_clear_ev || w_stop_ev || r_cnt == CW'(1)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_en_n  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_en_n   <= 1'b0;
                    r_mag_on <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.EN_N     = r_en_n;
    assign bus.MAG_ON   = r_mag_on;
    assign bus.DONE     = r_done;
    assign bus.MIN_TENS = r_mt;
    assign bus.MIN_ONES = r_mo;
    assign bus.SEC_TENS = r_st;
    assign bus.SEC_ONES = r_so;
endmodule

// File: doc/cook_timer_sequencer.md
# cook_timer_sequencer

Controller that owns the microwave cook time and sequences the keypad timer-input path. It accepts BCD digits from the keypad encoder (`D`/`LOAD_N`), assembles them into an MM:SS time, and enables the keypad (`EN_N`) only while idle. On start it counts the time down once per 1 Hz tick, drives the magnetron enable, and handles door interlock, stop, clear and completion. It sits between the timer input control and the display/magnetron drivers.

## Interface
- `DONE_CYCLES`, default 300: number of `CLK_100HZ` cycles that `DONE` stays high (3 s).
- `CLK_100HZ`  in  1  system clock; all logic is on its rising edge.
- `RST_N`  in  1  synchronous reset, active low.
- `D`  in  4  BCD digit from the keypad encoder.
- `LOAD_N`  in  1  active-low digit-valid level from the encoder.
- `TICK_1HZ`  in  1  1 Hz square wave from the timer input path.
- `START_N`, `STOP_N`, `CLEAR_N`  in  1 each  active-low buttons (debounced levels).
- `DOOR_CLOSED`  in  1  1 = door closed.
- `EN_N`  out  1  keypad encoder enable, active low.
- `MIN_TENS`, `MIN_ONES`, `SEC_TENS`, `SEC_ONES`  out  4 each  BCD time digits.
- `MAG_ON`  out  1  magnetron enable.
- `DONE`  out  1  cook-complete indicator.

## Operation
- Edge detection: each of `LOAD_N`, `START_N`, `STOP_N` and `CLEAR_N` has a previous-value register that resets to 1. An event is defined as previous value = 1 and current value = 0.
- `TICK_1HZ` has a previous-value register that resets to 0. A tick is previous value = 0 and current value = 1.
- States: IDLE, COOK, PAUSE, FINISH. Reset state is IDLE.
- Event priority within one cycle: CLEAR > door open > STOP > START > tick > LOAD.
- **IDLE**
  - LOAD event with `D` ≤ 9 shifts the digits left: `MIN_TENS`←`MIN_ONES`←`SEC_TENS`←`SEC_ONES`←`D`. The old `MIN_TENS` is discarded.
  - LOAD event with `D` > 9 is ignored.
  - START with `DOOR_CLOSED`=1 and time ≠ 0000 → COOK. START with time = 0000 or door open is ignored.
  - CLEAR zeroes all digits.
- **COOK**
  - Each tick decrements the time by one second in BCD.
    - `SEC_ONES` 0→9 with a borrow from `SEC_TENS`.
    - `SEC_TENS` 0→5 with a borrow from `MIN_ONES`.
    - `MIN_ONES` 0→9 with a borrow from `MIN_TENS`.
  - Entered seconds above 59 (e.g. 99) are not normalised. They count down directly: 0099→0098…→0059 borrow only at 00.
  - A decrement that yields 0000 → FINISH.
  - `DOOR_CLOSED`=0 → PAUSE with no decrement, even if a tick occurs in the same cycle.
  - STOP → PAUSE. A tick in the same cycle is still applied; if that tick yields 0000, the next state is FINISH.
  - CLEAR → IDLE with digits zeroed.
- **PAUSE**
  - Time is held.
  - START with door closed → COOK. Time ≠ 0 is guaranteed.
  - STOP → IDLE with time kept.
  - CLEAR → IDLE with digits zeroed.
  - Ticks are ignored.
- **FINISH**
  - Digits are 0000.
  - A down-counter loaded with `DONE_CYCLES` decrements every cycle. On reaching 0 → IDLE.
  - CLEAR or STOP → IDLE immediately.
  - START and LOAD are ignored.
- Outputs are registered:
  - `EN_N` = 0 only in IDLE.
  - `MAG_ON` = 1 only in COOK.
  - `DONE` = 1 only in FINISH.
- Reset mid-operation forces IDLE and zeroes the digits. `MAG_ON` drops on that edge.

## Timing
- Reset values:
  - digits 0000
  - `EN_N`=0
  - `MAG_ON`=0
  - `DONE`=0
  - edge registers as stated above
  - FINISH counter 0
- Input-to-output latency is one edge. An input level first sampled low (or high for a tick) at edge N produces the updated state, digits and outputs after edge N.
- A held button produces exactly one event. A new event requires the input to return high for at least one cycle.
- The door interlock acts at the first edge that samples `DOOR_CLOSED`=0. `MAG_ON` is 0 after that edge.
- `DONE` stays high for exactly `DONE_CYCLES` cycles, then the block is in IDLE with `EN_N`=0.

## Test plan
- **Key entry:** from reset, LOAD pulses with `D`=1,3,0 → digits 0130, `EN_N`=0. One more LOAD with `D`=0xA → digits unchanged.
- **Basic cook:**
  - Stimulus: time 0003, START, then 3 ticks.
  - Required: `MAG_ON`=1 one edge after START; digits 0002, 0001, 0000.
  - Required: FINISH after the third tick, `DONE`=1 for exactly 300 cycles, then IDLE.
- **BCD borrow:**
  - Stimulus: time 1000, one tick.
  - Required: 0959.
  - Stimulus: time 0099, one tick.
  - Required: 0098.
- **Door interlock:**
  - Stimulus: door opens in COOK in the same cycle as a tick.
  - Required: PAUSE, no decrement, `MAG_ON`=0 next edge.
  - Stimulus: START with door still open.
  - Required: ignored.
  - Stimulus: door closes, then START.
  - Required: COOK resumes.
- **Stop/clear:**
  - Stimulus: STOP in COOK.
  - Required: PAUSE with time held.
  - Stimulus: STOP again.
  - Required: IDLE with time held and `EN_N`=0.
  - Stimulus: CLEAR in PAUSE.
  - Required: 0000.
  - Stimulus: START at 0000.
  - Required: stays in IDLE.
- **Reset/priority:**
  - Stimulus: `RST_N`=0 mid-COOK.
  - Required: digits 0000 and `MAG_ON`=0 next edge.
  - Stimulus: CLEAR and START in the same cycle.
  - Required: IDLE with 0000.
